// File: rtl/gerenciador_atributos_pkg.sv
// Shared types for the pet attribute manager: state codes, attribute width,
// per-attribute control bundle and saturating arithmetic helpers.
package gerenciador_atributos_pkg;

    localparam int ATTR_W = 8;

    typedef logic [ATTR_W-1:0] attr_t;
    // One bit wider than an attribute so a doubled decay step still fits.
    typedef logic [ATTR_W:0]   passo_t;

    localparam attr_t ATTR_MAX = '1;

    typedef enum logic [3:0] {
        IDLE       = 4'b0000,
        DORMINDO   = 4'b0001,
        COMENDO    = 4'b0010,
        DANDO_AULA = 4'b0100,
        MORTO      = 4'b1000
    } estado_t;

    typedef struct packed {
        logic   soma;
        logic   subtrai;
        passo_t passo;
    } ctrl_attr_t;

    function automatic attr_t sat_add(input attr_t a, input passo_t b);
        logic [ATTR_W+1:0] s;
        s = {2'b00, a} + {1'b0, b};
        return (s > {2'b00, ATTR_MAX}) ? ATTR_MAX : s[ATTR_W-1:0];
    endfunction

    function automatic attr_t sat_sub(input attr_t a, input passo_t b);
        if ({1'b0, a} < b)
            return '0;
        return attr_t'({1'b0, a} - b);
    endfunction

endpackage

// File: rtl/gerenciador_atributos_atualiza_atributo.sv
// One registered attribute with saturating gain/decay and a freeze input.
// The combinational next value is exported so the top can detect a hit on 0.
import gerenciador_atributos_pkg::*;

module atualiza_atributo #(
    parameter int VALOR_INICIAL = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       congela,
    input  ctrl_attr_t ctrl,
    output attr_t      valor,
    output attr_t      proximo
);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        proximo = valor;
        if (!congela) begin
            if (ctrl.soma)
                proximo = sat_add(valor, ctrl.passo);
            else if (ctrl.subtrai)
                proximo = sat_sub(valor, ctrl.passo);
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valor <= attr_t'(VALOR_INICIAL);
        else
            valor <= proximo;
    end

endmodule

// File: rtl/gerenciador_atributos.sv
// Virtual-pet attribute manager: tick-gated decay/gain of fome, felicidade
// and sono driven by the pet state, with age counting and a sticky end flag.
import gerenciador_atributos_pkg::*;

module gerenciador_atributos #(
    parameter int PERIODO_DECAI = 4,
    parameter int PASSO_DECAI   = 1,
    parameter int PASSO_GANHO   = 4,
    parameter int VALOR_INICIAL = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] estado,
    output logic [7:0] fome,
    output logic [7:0] felicidade,
    output logic [7:0] sono,
    output logic [7:0] idade,
    output logic       fim
);

    localparam passo_t GANHO         = passo_t'(PASSO_GANHO);
    localparam passo_t DECAI_SIMPLES = passo_t'(PASSO_DECAI);
    localparam passo_t DECAI_DUPLO   = passo_t'(2 * PASSO_DECAI);
    localparam attr_t  ULTIMO_CNT    = attr_t'(PERIODO_DECAI - 1);

    attr_t      cnt;
    estado_t    modo;
    logic       ativo;
    logic       decai;
    logic       zera;
    ctrl_attr_t c_fome, c_fel, c_sono;
    attr_t      p_fome, p_fel, p_sono;

    // Unlisted encodings behave as IDLE.
    always_comb begin
        modo = IDLE;
        case (estado)
            DORMINDO, COMENDO, DANDO_AULA, MORTO: modo = estado_t'(estado);
            default:                              modo = IDLE;
        endcase
    end

    assign ativo = tick && !fim && (modo != MORTO);
    assign decai = ativo && (cnt == ULTIMO_CNT);

    always_comb begin
        c_fome = '{soma: 1'b0, subtrai: decai, passo: DECAI_SIMPLES};
        c_fel  = '{soma: 1'b0, subtrai: decai, passo: DECAI_SIMPLES};
        c_sono = '{soma: 1'b0, subtrai: decai, passo: DECAI_SIMPLES};
        case (modo)
            COMENDO: begin
                c_fome.soma  = 1'b1;
                c_fome.passo = GANHO;
            end
            DORMINDO: begin
                c_sono.soma  = 1'b1;
                c_sono.passo = GANHO;
            end
            DANDO_AULA: begin
                c_fel.soma   = 1'b1;
                c_fel.passo  = GANHO;
                c_fome.passo = DECAI_DUPLO;
                c_sono.passo = DECAI_DUPLO;
            end
            default: ;
        endcase
    end

    atualiza_atributo #(.VALOR_INICIAL(VALOR_INICIAL)) u_fome (
        .clk     (clk),
        .rst     (rst),
        .congela (!ativo),
        .ctrl    (c_fome),
        .valor   (fome),
        .proximo (p_fome)
    );

    atualiza_atributo #(.VALOR_INICIAL(VALOR_INICIAL)) u_felicidade (
        .clk     (clk),
        .rst     (rst),
        .congela (!ativo),
        .ctrl    (c_fel),
        .valor   (felicidade),
        .proximo (p_fel)
    );

    atualiza_atributo #(.VALOR_INICIAL(VALOR_INICIAL)) u_sono (
        .clk     (clk),
        .rst     (rst),
        .congela (!ativo),
        .ctrl    (c_sono),
        .valor   (sono),
        .proximo (p_sono)
    );

    // fim rises on the same edge that lands any attribute on 0.
    assign zera = ativo && ((p_fome == '0) || (p_fel == '0) || (p_sono == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            idade <= '0;
            fim   <= 1'b0;
        end else if (ativo) begin
            cnt <= decai ? '0 : cnt + 8'd1;
            if (decai && (idade != ATTR_MAX))
                idade <= idade + 8'd1;
            if (zera)
                fim <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gerenciador_atributos.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor
// pops and compares them against one of two DUT instances.
module tb_gerenciador_atributos;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] estado = 4'b0000;

    logic [7:0] fome_a, fel_a, sono_a, idade_a;
    logic       fim_a;
    logic [7:0] fome_b, fel_b, sono_b, idade_b;
    logic       fim_b;

    localparam logic [3:0] S_IDLE = 4'b0000, S_DORM = 4'b0001, S_COME = 4'b0010,
                           S_AULA = 4'b0100, S_MORTO = 4'b1000, S_INV = 4'b0011;

    gerenciador_atributos dut_a (
        .clk(clk), .rst(rst), .tick(tick), .estado(estado),
        .fome(fome_a), .felicidade(fel_a), .sono(sono_a), .idade(idade_a), .fim(fim_a)
    );

    gerenciador_atributos #(.VALOR_INICIAL(1)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .estado(estado),
        .fome(fome_b), .felicidade(fel_b), .sono(sono_b), .idade(idade_b), .fim(fim_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         dut_b;
        string      nome;
        logic [7:0] fo, fe, so, id;
        logic       fi;
    } esperado_t;

    esperado_t fila[$];
    event      amostrar;
    int        testes = 0;
    int        falhas = 0;

    // Monitor: drains the scoreboard whenever the stimulus marks a sample point.
    initial begin
        forever begin
            @(amostrar);
            while (fila.size() > 0) begin
                esperado_t e;
                logic [7:0] fo, fe, so, id;
                logic fi;
                e = fila.pop_front();
                if (e.dut_b) begin
                    fo = fome_b; fe = fel_b; so = sono_b; id = idade_b; fi = fim_b;
                end else begin
                    fo = fome_a; fe = fel_a; so = sono_a; id = idade_a; fi = fim_a;
                end
                testes++;
                if ({fo, fe, so, id, fi} !== {e.fo, e.fe, e.so, e.id, e.fi}) begin
                    falhas++;
                    $display("FAIL %s: got fome=%0d fel=%0d sono=%0d idade=%0d fim=%0b, want fome=%0d fel=%0d sono=%0d idade=%0d fim=%0b",
                             e.nome, fo, fe, so, id, fi, e.fo, e.fe, e.so, e.id, e.fi);
                end
            end
        end
    end

    task automatic espera(input bit b, input string n, input int fo, input int fe,
                          input int so, input int id, input bit fi);
        esperado_t e;
        e.dut_b = b; e.nome = n;
        e.fo = 8'(fo); e.fe = 8'(fe); e.so = 8'(so); e.id = 8'(id); e.fi = fi;
        fila.push_back(e);
        -> amostrar;
        #1;
    endtask

    task automatic pulsos(input int n, input logic [3:0] est);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            estado = est;
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic reinicia();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        espera(0, "reset_a", 200, 200, 200, 0, 0);
        espera(1, "reset_b", 1, 1, 1, 0, 0);
        rst = 1'b0;

        // IDLE decay every 4th tick
        pulsos(3, S_IDLE);
        espera(0, "idle_3", 200, 200, 200, 0, 0);
        pulsos(1, S_IDLE);
        espera(0, "idle_4", 199, 199, 199, 1, 0);
        pulsos(4, S_IDLE);
        espera(0, "idle_8", 198, 198, 198, 2, 0);

        // DANDO_AULA: gain on felicidade, double decay on the others
        reinicia();
        pulsos(4, S_AULA);
        espera(0, "aula_4", 198, 216, 198, 1, 0);

        // COMENDO up to saturation
        reinicia();
        pulsos(13, S_COME);
        espera(0, "come_13", 252, 197, 197, 3, 0);
        pulsos(1, S_COME);
        espera(0, "come_sat1", 255, 197, 197, 3, 0);
        pulsos(1, S_COME);
        espera(0, "come_sat2", 255, 197, 197, 3, 0);

        // Unlisted code behaves as IDLE; MORTO freezes everything incl. cnt
        reinicia();
        pulsos(4, S_INV);
        espera(0, "invalido_4", 199, 199, 199, 1, 0);
        pulsos(7, S_MORTO);
        espera(0, "morto_7", 199, 199, 199, 1, 0);
        @(negedge clk);
        estado = S_AULA;
        repeat (3) @(negedge clk);
        espera(0, "sem_tick", 199, 199, 199, 1, 0);
        pulsos(3, S_DORM);
        espera(0, "dorme_3", 199, 199, 211, 1, 0);
        pulsos(1, S_DORM);
        espera(0, "dorme_4", 198, 198, 215, 2, 0);

        // Asynchronous reset between edges discards cnt too
        reinicia();
        pulsos(6, S_IDLE);
        espera(0, "pre_rst", 199, 199, 199, 1, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        espera(0, "rst_async", 200, 200, 200, 0, 0);
        rst = 1'b0;
        pulsos(3, S_IDLE);
        espera(0, "pos_rst_3", 200, 200, 200, 0, 0);
        pulsos(1, S_IDLE);
        espera(0, "pos_rst_4", 199, 199, 199, 1, 0);

        // VALOR_INICIAL=1: decay to 0 sets fim and freezes
        reinicia();
        pulsos(3, S_IDLE);
        espera(1, "v1_idle_3", 1, 1, 1, 0, 0);
        pulsos(1, S_IDLE);
        espera(1, "v1_zero", 0, 0, 0, 1, 1);
        pulsos(10, S_COME);
        espera(1, "v1_congelado", 0, 0, 0, 1, 1);

        // Decrement larger than value saturates at 0
        reinicia();
        pulsos(3, S_AULA);
        espera(1, "v1_aula_3", 1, 13, 1, 0, 0);
        pulsos(1, S_AULA);
        espera(1, "v1_aula_4", 0, 17, 0, 1, 1);

        #1;
        if (fila.size() != 0) begin
            falhas++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", fila.size());
        end
        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule

// File: doc/gerenciador_atributos.md
GERENCIADOR_ATRIBUTOS -- requirements
Module: gerenciador_atributos

Interface
REQ-001 The block SHALL have parameter PERIODO_DECAI, default 4, meaning the number of tick pulses per decay step (legal range 1..255).
REQ-002 The block SHALL have parameter PASSO_DECAI, default 1, meaning the per-step decrement of each decaying attribute.
REQ-003 The block SHALL have parameter PASSO_GANHO, default 4, meaning the per-tick increment of the replenished attribute.
REQ-004 The block SHALL have parameter VALOR_INICIAL, default 200, meaning the reset value of every attribute.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 tick  input  1  one-cycle time-base pulse; all updates are gated by tick=1.
REQ-008 estado  input  4  pet state code: IDLE 0000, DORMINDO 0001, COMENDO 0010, DANDO_AULA 0100, MORTO 1000.
REQ-009 fome  output  8  satiety level; 0 means starved.
REQ-010 felicidade  output  8  happiness level; 0 means depressed.
REQ-011 sono  output  8  rest level; 0 means exhausted.
REQ-012 idade  output  8  completed decay steps, saturating at 255.
REQ-013 fim  output  1  sticky flag, set when any attribute reaches 0.

Function
REQ-014 All outputs SHALL be registered and SHALL change only on a clk edge where tick=1, using the estado value sampled at that edge.
REQ-015 Counter cnt (8 bit) SHALL increment on each tick; a tick with cnt=PERIODO_DECAI-1 is a decay step and SHALL wrap cnt to 0.
REQ-016 IDLE: on a decay step, fome, felicidade and sono SHALL each decrease by PASSO_DECAI.
REQ-017 COMENDO: fome SHALL increase by PASSO_GANHO on every tick; felicidade and sono SHALL decay per REQ-016.
REQ-018 DORMINDO: sono SHALL increase by PASSO_GANHO on every tick; fome and felicidade SHALL decay per REQ-016.
REQ-019 DANDO_AULA: felicidade SHALL increase by PASSO_GANHO on every tick; fome and sono SHALL decrease by 2*PASSO_DECAI on a decay step.
REQ-020 Any encoding other than the five listed SHALL be treated as IDLE.
REQ-021 MORTO: no attribute, cnt or idade SHALL change.
REQ-022 Increments SHALL saturate at 255; decrements SHALL saturate at 0 (value < step gives 0); no wrap-around.
REQ-023 idade SHALL increment on each decay step, saturating at 255.
REQ-024 fim SHALL be set on the same edge that drives any attribute to 0.
REQ-025 While fim=1, all attributes, cnt and idade SHALL be frozen regardless of estado or tick.
REQ-026 tick=0 SHALL hold all state; a change in estado without tick SHALL have no effect.

Reset
REQ-027 On rst=1, the block SHALL immediately (asynchronously) set fome=felicidade=sono=VALOR_INICIAL, cnt=0, idade=0 and fim=0.
REQ-028 rst asserted mid-operation SHALL discard all accumulated state; the first tick after release SHALL count as cnt 0->1.

Structure
REQ-029 The state encodings and the 8-bit attribute width SHALL live in the shared package, which the state controller also uses.
REQ-030 Sub-module atualiza_atributo (one registered attribute with saturating add/sub, and freeze, gain and decay inputs) SHALL be instantiated once each for fome, felicidade and sono.

Verification
REQ-031 Reset, estado=IDLE, 8 ticks -> fome=felicidade=sono=198, idade=2, fim=0.
REQ-032 estado=DANDO_AULA from reset, 4 ticks -> felicidade=216, fome=198, sono=198.
REQ-033 estado=COMENDO until fome=252, then 2 ticks -> fome 255, then 255 (saturated).
REQ-034 VALOR_INICIAL=1, IDLE, 4 ticks -> all 0, fim=1, idade=1; 10 further ticks in COMENDO -> no change.
REQ-035 estado=4'b0011, 4 ticks -> identical to IDLE (all 199); estado=MORTO, 8 ticks -> no change.
REQ-036 rst pulsed between clk edges after 6 IDLE ticks -> outputs return to 200 and idade=0 before the next edge; 4 further ticks -> 199.
